mdu_ex: RTL and testbench

- Multiply/divide unit in the execute stage, directly upstream of the EX/MEM pipeline register.
- Owns the HI/LO registers. Runs MULT/MULTU/DIV/DIVU as multi-cycle operations, and MTHI/MTLO as single-cycle writes.
- Supplies HI/LO read data for MFHI/MFLO.
- Provides a busy indication for the hazard unit.
- Honours the exception/interrupt request `req`, which also flushes the EX/MEM register.

---
 rtl/mdu_ex.sv | 135 +++++++++++++
 tb/tb_mdu_ex.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ex.sv
// Execute-stage multiply/divide unit owning HI/LO; multi-cycle MULT/DIV, single-cycle MTHI/MTLO.
// Optional MADD/MADDU/MSUB/MSUBU (ops 7-10) are enabled by defining MDU_MADD_EN.
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [4:0] MULT_N   = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N    = 5'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        res_wr_q, res_wr_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        op_valid, accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        a_mag  = a[31] ? (32'd0 - a) : a;
        b_mag  = b[31] ? (32'd0 - b) : b;
        q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        q_s    = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        r_s    = a[31] ? (32'd0 - r_mag) : r_mag;
        q_u    = (b == 32'd0) ? 32'd0 : a / b;
        r_u    = (b == 32'd0) ? 32'd0 : a % b;
    end

`ifdef MDU_MADD_EN
    logic [63:0] hilo;
    assign hilo     = {hi_q, lo_q};
    assign op_valid = (op >= 4'd1) && (op <= 4'd10);
`else
    assign op_valid = (op >= 4'd1) && (op <= 4'd6);
`endif

    assign accept = start && !req && (state_q == S_IDLE) && op_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_wr_d = res_wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT:  begin res_d = prod_s; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
                        OP_MULTU: begin res_d = prod_u; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
                        OP_DIV: begin
                            res_d    = {r_s, q_s};
                            res_wr_d = (b != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_BUSY;
                        end
                        OP_DIVU: begin
                            res_d    = {r_u, q_u};
                            res_wr_d = (b != 32'd0);
                            cnt_d    = DIV_N;
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        4'd7:  begin res_d = hilo + prod_s; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
                        4'd8:  begin res_d = hilo + prod_u; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
                        4'd9:  begin res_d = hilo - prod_s; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
                        4'd10: begin res_d = hilo - prod_u; res_wr_d = 1'b1; cnt_d = MULT_N; state_d = S_BUSY; end
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    if (res_wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            res_q    <= 64'd0;
            res_wr_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_wr_q <= res_wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_ex.sv
// Self-checking bench for mdu_ex: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_mdu_ex;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    mdu_ex #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic r);
        op = o; a = x; b = y; start = 1'b1; req = r;
        tick();
        start = 1'b0; req = 1'b0; op = 4'd0;
    endtask

    // Spec-level reference: plain 64-bit integer arithmetic on the operands.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] h, input logic [31:0] l,
                         output logic [31:0] nh, output logic [31:0] nl, output int cyc);
        longint sx, sy, p;
        logic [63:0] up, acc;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        up = {32'd0, x} * {32'd0, y};
        acc = {h, l};
        nh = h; nl = l; cyc = 0;
        case (o)
            4'd1: begin {nh, nl} = p; cyc = MC; end
            4'd2: begin {nh, nl} = up; cyc = MC; end
            4'd3: begin cyc = DC; if (y != 0) begin nl = 32'(sx / sy); nh = 32'(sx % sy); end end
            4'd4: begin cyc = DC; if (y != 0) begin nl = x / y; nh = x % y; end end
            4'd5: nh = x;
            4'd6: nl = x;
`ifdef MDU_MADD_EN
            4'd7:  begin {nh, nl} = acc + 64'(p); cyc = MC; end
            4'd8:  begin {nh, nl} = acc + up; cyc = MC; end
            4'd9:  begin {nh, nl} = acc - 64'(p); cyc = MC; end
            4'd10: begin {nh, nl} = acc - up; cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        issue(4'd5, h, 32'd0, 1'b0);
        issue(4'd6, l, 32'd0, 1'b0);
        cur_hi = h; cur_lo = l;
    endtask

    task automatic run_exp(input string name, input logic [3:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                           input int ecyc);
        int n;
        logic held;
        issue(o, x, y, 1'b0);
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 64) begin
            if (hi !== cur_hi || lo !== cur_lo) held = 1'b0;
            n++;
            tick();
        end
        chk({name, " cycles"}, 32'(n), 32'(ecyc));
        chk({name, " hold"}, {31'd0, held}, 32'd1);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d (%s)", o, x, y, hi, lo, n, name);
        cur_hi = eh; cur_lo = el;
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3]  = '{4'd4, 32'd7, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DC};
        vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h0, 32'h80000000, DC};
        vecs[5]  = '{4'd5, 32'h12345678, 32'd0, 32'd0, 32'd0, 32'h12345678, 32'd0, 0};
        vecs[6]  = '{4'd6, 32'hCAFEBABE, 32'd0, 32'd1, 32'd2, 32'd1, 32'hCAFEBABE, 0};
        vecs[7]  = '{4'd0, 32'hAAAA5555, 32'd9, 32'd5, 32'd6, 32'd5, 32'd6, 0};
        vecs[8]  = '{4'd11, 32'hAAAA5555, 32'd9, 32'd5, 32'd6, 32'd5, 32'd6, 0};
        vecs[9]  = '{4'd4, 32'hFFFFFFFF, 32'd16, 32'd0, 32'd0, 32'h0000000F, 32'h0FFFFFFF, DC};
        vecs[10] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFD, DC};
        vecs[11] = '{4'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 32'd0, MC};
        vecs[12] = '{4'd3, 32'd5, 32'd0, 32'h77, 32'h88, 32'h77, 32'h88, DC};
`ifdef MDU_MADD_EN
        vecs[13] = '{4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, MC};
`else
        vecs[13] = '{4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 0};
`endif

        // Reset state
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            preset(vecs[i].pre_hi, vecs[i].pre_lo);
            run_exp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc);
        end

        // MTHI blocked by req, then accepted
        preset(32'hAA, 32'hBB);
        issue(4'd5, 32'h12345678, 32'd0, 1'b1);
        chk("mthi req hi", hi, 32'hAA);
        chk("mthi req busy", {31'd0, busy}, 32'd0);
        issue(4'd5, 32'h12345678, 32'd0, 1'b0);
        chk("mthi hi", hi, 32'h12345678);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        $display("mthi sequence: hi=%h lo=%h", hi, lo);
        cur_hi = 32'h12345678; cur_lo = 32'hBB;

        // MULT with req in busy cycle 2 and MTLO attempt in cycle 3
        begin
            int n;
            issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
            n = 0;
            while (busy === 1'b1 && n < 64) begin
                n++;
                req   = (n == 2);
                start = (n == 3);
                op    = (n == 3) ? 4'd6 : 4'd0;
                a     = 32'hDEADBEEF;
                tick();
            end
            req = 1'b0; start = 1'b0; op = 4'd0;
            chk("mult req cycles", 32'(n), 32'(MC));
            chk("mult req hi", hi, 32'hFFFFFFFF);
            chk("mult req lo", lo, 32'hFFFFFFFA);
            $display("mult+req+mtlo: hi=%h lo=%h busy_cycles=%0d", hi, lo, n);
            cur_hi = 32'hFFFFFFFF; cur_lo = 32'hFFFFFFFA;
        end

        // Asynchronous reset 3 cycles into a DIV
        preset(32'h1234, 32'h5678);
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset hi", hi, 32'd0);
        chk("async reset lo", lo, 32'd0);
        $display("async reset mid-div: busy=%b hi=%h lo=%h", busy, hi, lo);
        #1 reset = 1'b0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        tick();
        chk("post-reset busy", {31'd0, busy}, 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y, nh, nl;
            int          cyc;
            o = 4'($urandom_range(1, 10));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 9));
                2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                default: ;
            endcase
            model(o, x, y, cur_hi, cur_lo, nh, nl, cyc);
            run_exp($sformatf("rand%0d", i), o, x, y, nh, nl, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
